// File: rtl/aes_ct_serializer.sv
// aes_ct_serializer: buffers 128-bit AES ciphertext blocks in a DEPTH-entry
// FIFO and streams them out one byte per handshake, most significant byte
// first. The input side has no backpressure; a block arriving while the FIFO
// is full (and not popping) is dropped and sets a sticky overflow flag.
// Optional feature: define AES_SER_LAST_EN to add the out_last port, which
// marks the final byte of each block.
module aes_ct_serializer #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [127:0]               in_data,
  input  logic                       in_valid,
  output logic [7:0]                 out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     level,
`ifdef AES_SER_LAST_EN
  output logic                       out_last,
`endif
  output logic                       ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  // Storage is never reset; only pointers, counters and flags are.
  logic [127:0]  mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [3:0]    idx_q, idx_d;
  logic          ovf_q, ovf_d;

  logic          full;
  logic          xfer;
  logic          pop;
  logic          push;
  logic          drop;
  logic [127:0]  head;
  logic [6:0]    shamt;
  logic [127:0]  head_sh;

  // Handshake decode and byte selection from the head entry.
  always_comb begin
    out_valid = !rst && (level_q != '0);
    full      = (level_q == LW'(DEPTH));
    xfer      = out_valid && out_ready;
    pop       = xfer && (idx_q == 4'hf);
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    push      = in_valid && (!full || pop);
    drop      = in_valid && full && !pop;
    head      = mem_q[rd_ptr_q];
    // Byte 0 is bits [127:120], so shift right by 8*(15-idx).
    shamt     = {4'hf - idx_q, 3'b000};
    head_sh   = head >> shamt;
    out_data  = out_valid ? head_sh[7:0] : 8'h00;
    level     = level_q;
    ovf       = ovf_q;
  end

`ifdef AES_SER_LAST_EN
  // Flags the last byte of the current block.
  always_comb begin
    out_last = out_valid && (idx_q == 4'hf);
  end
`endif

  // Next-state for pointers, byte counter, occupancy and overflow flag.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    idx_d    = idx_q;
    ovf_d    = ovf_q;
    if (rst) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      idx_d    = '0;
      ovf_d    = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (xfer) idx_d    = idx_q + 4'd1;
      if (push && !pop)      level_d = level_q + LW'(1);
      else if (pop && !push) level_d = level_q - LW'(1);
      if (drop) ovf_d = 1'b1;
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    wr_ptr_q <= wr_ptr_d;
    rd_ptr_q <= rd_ptr_d;
    level_q  <= level_d;
    idx_q    <= idx_d;
    ovf_q    <= ovf_d;
  end

  // FIFO storage write; writes presented during reset are discarded.
  always_ff @(posedge clk) begin
    if (push && !rst) mem_q[wr_ptr_q] <= in_data;
  end

endmodule

// File: tb/tb_aes_ct_serializer.sv
// Scoreboard bench for aes_ct_serializer (DEPTH=4). Expected bytes are queued
// when a block is written and popped by a negedge monitor on each transfer.
module tb_aes_ct_serializer;

  localparam int DEPTH = 4;

  logic         clk;
  logic         rst;
  logic [127:0] in_data;
  logic         in_valid;
  logic [7:0]   out_data;
  logic         out_valid;
  logic         out_ready;
  logic [$clog2(DEPTH):0] level;
  logic         ovf;
`ifdef AES_SER_LAST_EN
  logic         out_last;
`endif

  aes_ct_serializer #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level),
`ifdef AES_SER_LAST_EN
    .out_last  (out_last),
`endif
    .ovf       (ovf)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] sb[$];
  int  tb_idx = 0;
  logic prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Queue the first nbytes bytes of a block, MSB first.
  task automatic push_blk(input logic [127:0] b, input int nbytes);
    for (int i = 0; i < nbytes; i++) sb.push_back(b[127 - 8*i -: 8]);
  endtask

  task automatic write_blk(input logic [127:0] b);
    in_data  = b;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    bit done = 0;
    for (int c = 0; c < budget && !done; c++) begin
      if (level == '0 && sb.size() == 0) done = 1;
      else step();
    end
    chk(tag, done, 1);
    chk({tag, "_sb_empty"}, sb.size(), 0);
  endtask

  // Output monitor: byte compare on transfers, hold on stalls, zero when idle.
  always @(negedge clk) begin
    if (prev_stall) chk("hold", out_data, prev_data);
    if (!out_valid) chk("idle_zero", out_data, 8'h00);
    if (rst) begin
      tb_idx = 0;
    end else if (out_valid && out_ready) begin
`ifdef AES_SER_LAST_EN
      chk("last", out_last, (tb_idx == 15));
`endif
      if (sb.size() == 0) chk("unexpected_byte", out_data, 8'hxx);
      else chk("byte", out_data, sb.pop_front());
      tb_idx = (tb_idx + 1) % 16;
    end
`ifdef AES_SER_LAST_EN
    else if (!out_valid) chk("last_idle", out_last, 1'b0);
`endif
    prev_stall = !rst && out_valid && !out_ready;
    prev_data  = out_data;
  end

  logic [127:0] blk0, blk1, blk2, blk3, blk4;

  initial begin
    blk0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    blk1 = 128'h00112233445566778899aabbccddeeff;
    blk2 = 128'hf0e1d2c3b4a5968778695a4b3c2d1e0f;
    blk3 = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
    blk4 = 128'hdeadbeefcafebabe0123456789abcdef;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    // Reset state, with a write presented during reset that must be discarded.
    step(); in_data = blk4; in_valid = 1'b1; step(); in_valid = 1'b0;
    @(negedge clk);
    chk("rst_level", level, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 8'h00);
    step(); rst = 1'b0; step();
    chk("post_rst_level", level, 0);

    // Single block, ready always high: one-cycle latency, 16 consecutive bytes.
    out_ready = 1'b1;
    in_data = blk0; in_valid = 1'b1;
    push_blk(blk0, 16);
    @(negedge clk);
    chk("lat_before", out_valid, 0);
    step(); in_valid = 1'b0;
    @(negedge clk);
    chk("lat_after", out_valid, 1);
    repeat (16) @(posedge clk);
    #1;
    chk("single_sb", sb.size(), 0);
    chk("single_level", level, 0);
    chk("single_valid", out_valid, 0);

    // Backpressure with ready toggling 1,0,1,0.
    out_ready = 1'b0;
    push_blk(blk0, 16);
    write_blk(blk0);
    for (int c = 0; c < 80 && level != '0; c++) begin
      out_ready = ~out_ready;
      step();
    end
    drain("bp_drain", 5);

    // Overflow: five writes with ready low; fifth dropped.
    out_ready = 1'b0;
    push_blk(blk1, 16); push_blk(blk2, 16); push_blk(blk3, 16); push_blk(blk0, 16);
    write_blk(blk1); write_blk(blk2); write_blk(blk3);
    in_data = blk0; in_valid = 1'b1; step();
    in_data = blk4;
    @(negedge clk);
    chk("ovf_full_level", level, 4);
    chk("ovf_before", ovf, 0);
    step(); in_valid = 1'b0;
    @(negedge clk);
    chk("ovf_level", level, 4);
    chk("ovf_set", ovf, 1);
    step();
    out_ready = 1'b1;
    drain("ovf_drain", 100);
    chk("ovf_sticky", ovf, 1);
    rst = 1'b1; step();
    @(negedge clk);
    chk("ovf_clear", ovf, 0);
    step(); rst = 1'b0;

    // Full FIFO with a write coinciding with the byte-15 pop.
    out_ready = 1'b0;
    push_blk(blk1, 16); push_blk(blk2, 16); push_blk(blk3, 16);
    push_blk(blk0, 16); push_blk(blk4, 16);
    write_blk(blk1); write_blk(blk2); write_blk(blk3); write_blk(blk0);
    out_ready = 1'b1;
    repeat (15) step();
    in_data = blk4; in_valid = 1'b1;
    step(); in_valid = 1'b0;
    @(negedge clk);
    chk("fullpop_level", level, 4);
    chk("fullpop_ovf", ovf, 0);
    drain("fullpop_drain", 100);

    // Reset after 7 bytes of A with B queued; C must come out first afterwards.
    out_ready = 1'b0;
    push_blk(blk2, 7);
    write_blk(blk2); write_blk(blk3);
    out_ready = 1'b1;
    repeat (7) step();
    rst = 1'b1;
    in_data = blk4; in_valid = 1'b1;
    step(); in_valid = 1'b0;
    @(negedge clk);
    chk("midrst_level", level, 0);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_data", out_data, 8'h00);
    chk("midrst_sb", sb.size(), 0);
    step(); rst = 1'b0;
    push_blk(blk1, 16);
    write_blk(blk1);
    drain("midrst_drain", 40);
    repeat (3) step();
    chk("final_level", level, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/aes_ct_serializer.md
AES_CT_SERIALIZER -- requirements
Module: aes_ct_serializer

Interface
REQ-001 The block SHALL use the parameter DEPTH, default 4, as the number of 128-bit ciphertext FIFO entries; legal values are powers of two from 2 to 16.
REQ-002 The block SHALL have port clk, input, 1 bit: the clock; all logic is on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-004 The block SHALL have port in_data, input, 128 bits: the ciphertext block from the AES encryption pipeline.
REQ-005 The block SHALL have port in_valid, input, 1 bit: in_data is valid this cycle; there is no backpressure toward the AES pipeline.
REQ-006 The block SHALL have port out_data, output, 8 bits: the serialized ciphertext byte.
REQ-007 The block SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-008 The block SHALL have port out_ready, input, 1 bit: the downstream sink accepts out_data.
REQ-009 The block SHALL have port level, output, $clog2(DEPTH)+1 bits: the number of occupied FIFO entries.
REQ-010 The block SHALL have port ovf, output, 1 bit: sticky overflow flag.
REQ-011 The block SHALL have port out_last, output, 1 bit, present only when the Configuration macro is defined: the current byte is the final byte of its block.

Function
REQ-012 When in_valid=1 and the FIFO is not full, or it is full and a pop occurs in the same cycle, the block SHALL write in_data at the write pointer; the write pointer wraps modulo DEPTH.
REQ-013 When in_valid=1, the FIFO is full and no pop occurs that cycle, the block SHALL drop in_data, leave the FIFO contents unchanged and set ovf to 1 from the next cycle until reset.
REQ-014 The block SHALL assert out_valid exactly when level != 0; it SHALL rise in the cycle after a write into an empty FIFO (one-cycle latency).
REQ-015 Bytes SHALL be emitted MSB first: byte index i (0..15) of the head entry is head[127-8i -: 8].
REQ-016 A byte transfer SHALL occur only on a cycle where out_valid=1 and out_ready=1; on that cycle the byte counter SHALL increment.
REQ-017 A transfer at byte index 15 SHALL wrap the byte counter to 0 and pop the head entry, advancing the read pointer modulo DEPTH.
REQ-018 While out_valid=1 and out_ready=0, out_data, the byte index and the head entry SHALL remain stable.
REQ-019 When a push and a pop occur in the same cycle, level SHALL remain unchanged.
REQ-020 level SHALL never exceed DEPTH and never go below 0.
REQ-021 out_data SHALL be 8'h00 whenever out_valid=0.
REQ-022 out_ready=1 while the FIFO is empty SHALL have no effect.

Reset
REQ-023 While rst=1, the block SHALL clear the read/write pointers, the byte counter, level and ovf to 0.
REQ-024 While rst=1, the block SHALL drive out_valid=0, out_data=8'h00 and out_last=0.
REQ-025 rst SHALL take priority over in_valid and out_ready in the same cycle; writes presented during reset are discarded.
REQ-026 Reset asserted mid-block SHALL abandon the partially sent block; the first byte after reset SHALL be byte 0 of the next block written.
REQ-027 FIFO storage contents SHALL NOT require reset.

Configuration
REQ-028 With macro AES_SER_LAST_EN defined, port out_last SHALL exist and equal out_valid AND (byte index == 15).
REQ-029 With AES_SER_LAST_EN undefined, port out_last and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-030 Single block, out_ready=1: in_data=128'h69c4e0d86a7b0430d8cdb78070b4c55a pulsed at cycle n -> out_valid rises at n+1; bytes 69,c4,e0,...,c5,5a on 16 consecutive cycles; level returns to 0; out_last=1 only on byte 5a.
REQ-031 Backpressure: same block with out_ready toggled 1,0,1,0 -> the byte sequence is unchanged and out_data is held on every ready=0 cycle.
REQ-032 Overflow: DEPTH+1 in_valid pulses with out_ready=0 -> level=4, ovf=1 after the fifth pulse; the draining output is blocks 1-4 only; ovf stays 1 until rst.
REQ-033 Full plus simultaneous pop: FIFO full, in_valid coincides with the transfer of byte 15 -> the write is accepted, level stays 4 and ovf stays 0.
REQ-034 Reset mid-block: rst asserted after 7 bytes of block A while block B is queued -> level=0 and out_valid=0; after reset, a new block C emits byte 0 of C first, and A and B are never emitted.
